// File: rtl/ror32_if.sv
// ror32_if: operand/amount/result bundle for the ror32 rotate-right unit.
// The master drives the operand and rotate amount and observes the result;
// the slave (the rotator) consumes the inputs and drives the result.
interface ror32_if;
  logic [31:0] Ra;         // operand to rotate
  logic [4:0]  shift_amt;  // rotate-right amount, 0..31
  logic [31:0] result;     // registered rotated value

  modport master (
    output Ra,
    output shift_amt,
    input  result
  );

  modport slave (
    input  Ra,
    input  shift_amt,
    output result
  );
endinterface

// File: rtl/ror32.sv
// ror32: 32-bit registered rotate-right for the ALU ROR instruction.
// A five-stage logarithmic barrel rotator (1, 2, 4, 8, 16 positions) feeds
// a single output register, so each input pair produces its result one
// cycle later with a throughput of one per cycle.
module ror32 (
  input  logic   clk,
  input  logic   reset,
  ror32_if.slave bus
);

  // stage_w[0] is the raw operand; stage_w[k+1] is stage_w[k] optionally
  // rotated by 2**k. Every stage is a pure wire permutation, so no bit is
  // ever zero-filled and all 32 amounts are well defined.
  logic [31:0] stage_w [0:5];
  logic [31:0] result_d;
  logic [31:0] result_q;

  assign stage_w[0] = bus.Ra;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      localparam int AMT = 1 << gi;
      logic [31:0] rot_w;
      // Rotate right by AMT: the low AMT bits wrap around to the top.
      assign rot_w          = {stage_w[gi][AMT-1:0], stage_w[gi][31:AMT]};
      assign stage_w[gi+1]  = bus.shift_amt[gi] ? rot_w : stage_w[gi];
    end
  endgenerate

  assign result_d = stage_w[5];

  // Output register; reset wins over the data load.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'h0000_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_ror32.sv
// tb_ror32: scoreboard bench for ror32. The driver issues one input pair per
// cycle and queues the expected result with the cycle it should appear; a
// separate monitor compares the DUT output against the queue head.
module tb_ror32;

  logic clk;
  logic reset;
  ror32_if bus ();

  ror32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] ra;
    bit          chk_pop;
    int          due;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int cycle = 0;
  int check_total = 0;
  int check_pass  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference rotate: bit i of the result is bit (i + s) mod 32 of the operand.
  function automatic logic [31:0] rotr_model(input logic [31:0] a, input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
    return r;
  endfunction

  task automatic issue(input logic rst, input logic [31:0] a, input logic [4:0] s,
                       input logic [31:0] exp, input bit pop, input string tag);
    sb_entry_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.Ra        = a;
    bus.shift_amt = s;
    e.exp = exp; e.ra = a; e.chk_pop = pop; e.due = cycle + 1; e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation whose cycle has come.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      sb_entry_t e;
      e = sb.pop_front();
      check_total++;
      if (bus.result === e.exp) begin
        check_pass++;
        $display("check %s: result=%08h ok", e.tag, bus.result);
      end else begin
        $display("FAIL %s: result=%08h expected=%08h", e.tag, bus.result, e.exp);
      end
      if (e.chk_pop) begin
        check_total++;
        if ($countones(bus.result) == $countones(e.ra)) check_pass++;
        else $display("FAIL %s popcount: got %0d expected %0d", e.tag,
                      $countones(bus.result), $countones(e.ra));
      end
    end
  end

  initial begin
    logic [31:0] a;
    int wait_cnt;
    reset = 1'b1;
    bus.Ra = 32'h0;
    bus.shift_amt = 5'd0;

    // Reset with live inputs, then release.
    issue(1'b1, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 1'b0, "reset0");
    issue(1'b1, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 1'b0, "reset1");
    issue(1'b0, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 1'b1, "release");

    // Directed boundary cases with hand-derived expectations.
    issue(1'b0, 32'hF0F0_F0F0, 5'd0,  32'hF0F0_F0F0, 1'b1, "zero_rot");
    issue(1'b0, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F0F, 1'b1, "rot4");
    issue(1'b0, 32'h1234_5678, 5'd16, 32'h5678_1234, 1'b1, "hw_swap");
    issue(1'b0, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, "wrap1");
    issue(1'b0, 32'hAAAA_AAAA, 5'd31, 32'h5555_5555, 1'b1, "max_aa");
    issue(1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b1, "max_msb");
    issue(1'b0, 32'h0000_0000, 5'd13, 32'h0000_0000, 1'b1, "all_zero");
    issue(1'b0, 32'hFFFF_FFFF, 5'd27, 32'hFFFF_FFFF, 1'b1, "all_ones");

    // Back-to-back pipelining.
    issue(1'b0, 32'h1234_5678, 5'd4,  32'h8123_4567, 1'b1, "pipe4");
    issue(1'b0, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b1, "pipe8");
    issue(1'b0, 32'h1234_5678, 5'd12, 32'h6781_2345, 1'b1, "pipe12");

    // Held inputs keep producing the same value.
    for (int k = 0; k < 3; k++)
      issue(1'b0, 32'hDEAD_BEEF, 5'd7, 32'hDFBD_5B7D, 1'b1, "hold");

    // Mid-stream reset, then recovery.
    issue(1'b1, 32'hCAFE_F00D, 5'd3, 32'h0000_0000, 1'b0, "reset_mid");
    issue(1'b0, 32'hCAFE_F00D, 5'd3, rotr_model(32'hCAFE_F00D, 3), 1'b1, "recover");

    // Random sweep over every amount.
    for (int s = 0; s < 32; s++) begin
      for (int k = 0; k < 4; k++) begin
        a = $urandom();
        issue(1'b0, a, 5'(s), rotr_model(a, s), 1'b1, $sformatf("rand_s%0d", s));
      end
    end

    // Drain with a bounded wait.
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    if (sb.size() > 0) begin
      check_total++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", check_pass, check_total);
    $finish;
  end

endmodule
